// File: rtl/traffic_phase_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_controller_if
// Description : Bundle of the signals between the phase controller, the
//               per-direction sensors, the timebase and the signal lamps.
//               master = controller side, slave = sensor/lamp environment.
// Revision    : 1.0  initial release
// ============================================================================
interface traffic_phase_controller_if;
   logic       tick;
   logic [7:0] avg_north;
   logic [7:0] avg_east;
   logic [7:0] avg_south;
   logic [7:0] avg_west;
   logic [1:0] next_road;
   logic [3:0] green;
   logic [3:0] yellow;
   logic       all_red;
   logic [7:0] green_len;
   logic [7:0] remaining;
   logic       phase_start;

   modport master (
      input  tick, avg_north, avg_east, avg_south, avg_west,
      output next_road, green, yellow, all_red, green_len, remaining, phase_start
   );

   modport slave (
      output tick, avg_north, avg_east, avg_south, avg_west,
      input  next_road, green, yellow, all_red, green_len, remaining, phase_start
   );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_controller
// Description : Four-way signal controller. Rotates through the roads,
//               sizes each green from the road's sensor average and runs
//               the lamps through GREEN -> YELLOW -> all-red -> SELECT.
//               Optional macro PRIORITY_SKIP_EN: skip roads whose average
//               is below SKIP_THRESH when choosing the next road.
// Revision    : 1.0  initial release
// ============================================================================
module traffic_phase_controller #(
   parameter int MIN_GREEN   = 5,
   parameter int MAX_GREEN   = 30,
   parameter int YELLOW_T    = 3,
   parameter int ALL_RED_T   = 1,
   parameter int SCALE_SHIFT = 2,
   parameter int SKIP_THRESH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   traffic_phase_controller_if.master    bus
);

   typedef enum logic [1:0] {
      RED_CLR = 2'd0,
      SELECT  = 2'd1,
      GREEN   = 2'd2,
      YELLOW  = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] road, road_nxt;
   logic [7:0] glen, glen_nxt;
   logic [7:0] rem, rem_nxt;
   logic       pstart, pstart_nxt;
   logic [3:0] green, green_nxt;
   logic [3:0] yellow, yellow_nxt;
   logic       all_red, all_red_nxt;

   logic [7:0] avg_arr [4];
   logic [1:0] cand;
   logic [8:0] sum;
   logic [7:0] glen_calc;
   logic       expire;

   assign avg_arr[0] = bus.avg_north;
   assign avg_arr[1] = bus.avg_east;
   assign avg_arr[2] = bus.avg_south;
   assign avg_arr[3] = bus.avg_west;

   // A timed phase ends on the tick that would take remaining from 1 to 0.
   assign expire = bus.tick && (rem == 8'd1);

`ifndef PRIORITY_SKIP_EN
   logic unused_skip_thresh;
   assign unused_skip_thresh = &{1'b0, 8'(SKIP_THRESH)};
`endif

   // Choose the candidate road and size its green time (9-bit sum, saturated).
   always_comb begin
      logic [1:0] idx;
      logic       found;
      idx   = 2'd0;
      found = 1'b0;
      cand  = road + 2'd1;
`ifdef PRIORITY_SKIP_EN
      // Search the next three roads, then the current one, for enough demand.
      for (int k = 1; k <= 4; k++) begin
         idx = road + 2'(k);
         if (!found && (avg_arr[idx] >= 8'(SKIP_THRESH))) begin
            cand  = idx;
            found = 1'b1;
         end
      end
`endif
      sum       = 9'(MIN_GREEN) + {1'b0, (avg_arr[cand] >> SCALE_SHIFT)};
      glen_calc = (sum > 9'(MAX_GREEN)) ? 8'(MAX_GREEN) : sum[7:0];
   end

   // Next-state and next-output logic of the phase sequencer.
   always_comb begin
      state_nxt  = state;
      road_nxt   = road;
      glen_nxt   = glen;
      rem_nxt    = rem;
      pstart_nxt = 1'b0;
      // SELECT never consumes a tick; every timed phase counts down on tick.
      if (bus.tick && (state != SELECT)) begin
         rem_nxt = rem - 8'd1;
      end
      case (state)
         RED_CLR: begin
            if (expire) begin
               state_nxt = SELECT;
            end
         end
         SELECT: begin
            road_nxt   = cand;
            glen_nxt   = glen_calc;
            rem_nxt    = glen_calc;
            pstart_nxt = 1'b1;
            state_nxt  = GREEN;
         end
         GREEN: begin
            if (expire) begin
               state_nxt = YELLOW;
               rem_nxt   = 8'(YELLOW_T);
            end
         end
         YELLOW: begin
            if (expire) begin
               state_nxt = RED_CLR;
               rem_nxt   = 8'(ALL_RED_T);
            end
         end
         default: begin
            state_nxt = RED_CLR;
            rem_nxt   = 8'(ALL_RED_T);
         end
      endcase
      // Lamps follow the upcoming state so they are registered with it.
      green_nxt   = (state_nxt == GREEN)  ? (4'b0001 << road_nxt) : 4'b0000;
      yellow_nxt  = (state_nxt == YELLOW) ? (4'b0001 << road_nxt) : 4'b0000;
      all_red_nxt = (state_nxt == RED_CLR);
   end

   // State and output registers; reset restarts the rotation so N is next.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RED_CLR;
         road    <= 2'd3;
         glen    <= 8'd0;
         rem     <= 8'(ALL_RED_T);
         pstart  <= 1'b0;
         green   <= 4'b0000;
         yellow  <= 4'b0000;
         all_red <= 1'b1;
      end else begin
         state   <= state_nxt;
         road    <= road_nxt;
         glen    <= glen_nxt;
         rem     <= rem_nxt;
         pstart  <= pstart_nxt;
         green   <= green_nxt;
         yellow  <= yellow_nxt;
         all_red <= all_red_nxt;
      end
   end

   assign bus.next_road   = road;
   assign bus.green       = green;
   assign bus.yellow      = yellow;
   assign bus.all_red     = all_red;
   assign bus.green_len   = glen;
   assign bus.remaining   = rem;
   assign bus.phase_start = pstart;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_controller
// Description : Self-checking bench for traffic_phase_controller with a
//               phase-schedule reference model (elapsed ticks vs. length).
// Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_phase_controller;
   localparam int MIN_GREEN   = 5;
   localparam int MAX_GREEN   = 30;
   localparam int YELLOW_T    = 3;
   localparam int ALL_RED_T   = 1;
   localparam int SCALE_SHIFT = 2;
   localparam int SKIP_THRESH = 4;

   localparam int P_RED = 0, P_SEL = 1, P_GRN = 2, P_YEL = 3;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   traffic_phase_controller_if bus ();

   traffic_phase_controller #(
      .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_T(YELLOW_T),
      .ALL_RED_T(ALL_RED_T), .SCALE_SHIFT(SCALE_SHIFT), .SKIP_THRESH(SKIP_THRESH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model: phase kind, served road, latched green, phase length
   // and ticks already spent in the phase.
   int m_phase, m_road, m_glen, m_len, m_tks, m_pstart;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int avg_of(input int r);
      case (r)
         0: return int'(bus.avg_north);
         1: return int'(bus.avg_east);
         2: return int'(bus.avg_south);
         default: return int'(bus.avg_west);
      endcase
   endfunction

   function automatic int pick_road(input int cur);
`ifdef PRIORITY_SKIP_EN
      for (int k = 1; k <= 4; k++) begin
         if (avg_of((cur + k) % 4) >= SKIP_THRESH) return (cur + k) % 4;
      end
`endif
      return (cur + 1) % 4;
   endfunction

   task automatic model_step();
      int a, g;
      if (reset) begin
         m_phase = P_RED; m_road = 3; m_glen = 0;
         m_len = ALL_RED_T; m_tks = 0; m_pstart = 0;
         return;
      end
      m_pstart = 0;
      if (m_phase == P_SEL) begin
         m_road   = pick_road(m_road);
         a        = avg_of(m_road);
         g        = MIN_GREEN + a / (1 << SCALE_SHIFT);
         m_glen   = (g > MAX_GREEN) ? MAX_GREEN : g;
         m_phase  = P_GRN; m_len = m_glen; m_tks = 0;
         m_pstart = 1;
      end else if (bus.tick) begin
         m_tks++;
         if (m_tks == m_len) begin
            case (m_phase)
               P_RED:   m_phase = P_SEL;  // remaining reads len - tks = 0
               P_GRN:   begin m_phase = P_YEL; m_len = YELLOW_T;  m_tks = 0; end
               default: begin m_phase = P_RED; m_len = ALL_RED_T; m_tks = 0; end
            endcase
         end
      end
   endtask

   task automatic cycle();
      logic [3:0] lamps;
      @(posedge clk);
      model_step();
      #1;
      check("next_road",   32'(bus.next_road),   32'(m_road));
      check("green",       32'(bus.green),       (m_phase == P_GRN) ? (32'd1 << m_road) : 32'd0);
      check("yellow",      32'(bus.yellow),      (m_phase == P_YEL) ? (32'd1 << m_road) : 32'd0);
      check("all_red",     32'(bus.all_red),     32'(m_phase == P_RED));
      check("green_len",   32'(bus.green_len),   32'(m_glen));
      check("remaining",   32'(bus.remaining),   32'(m_len - m_tks));
      check("phase_start", 32'(bus.phase_start), 32'(m_pstart));
      lamps = bus.green | bus.yellow;
      check("lamp_excl", 32'(($countones(lamps) <= 1) && !(bus.all_red && (lamps != 4'b0))), 32'd1);
   endtask

   task automatic set_avgs(input int n, input int e, input int s, input int w);
      bus.avg_north = 8'(n); bus.avg_east = 8'(e);
      bus.avg_south = 8'(s); bus.avg_west = 8'(w);
   endtask

   function automatic int rand_avg();
      case ($urandom_range(0, 3))
         0: return int'($urandom_range(0, 7));
         1: return 255;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      int roads[$];
      int glens[$];
      bit seen_s, seen_w, found;

      reset    = 1'b1;
      bus.tick = 1'b0;
      set_avgs(20, 20, 20, 20);
      cycle();
      cycle();
      check("rst_road",    32'(bus.next_road), 32'd3);
      check("rst_all_red", 32'(bus.all_red),   32'd1);
      check("rst_rem",     32'(bus.remaining), 32'(ALL_RED_T));
      check("rst_glen",    32'(bus.green_len), 32'd0);

      // All averages 20, tick every clock: rotation N,E,S,W,N with green 10.
      reset    = 1'b0;
      bus.tick = 1'b1;
      for (int i = 0; i < 80; i++) begin
         cycle();
         if (bus.phase_start) begin
            roads.push_back(int'(bus.next_road));
            glens.push_back(int'(bus.green_len));
         end
      end
      check("rr_starts", 32'(roads.size() >= 5), 32'd1);
      for (int i = 0; i < 5 && i < roads.size(); i++) begin
         check("rr_road", 32'(roads[i]), 32'(i % 4));
         check("rr_glen", 32'(glens[i]), 32'd10);
      end

      // Saturation and minimum green.
      set_avgs(20, 20, 255, 0);
      seen_s = 1'b0;
      seen_w = 1'b0;
      for (int i = 0; i < 80; i++) begin
         cycle();
         if (bus.phase_start && bus.next_road == 2'd2) begin
            seen_s = 1'b1;
            check("sat_glen", 32'(bus.green_len), 32'd30);
         end
         if (bus.phase_start && bus.next_road == 2'd3) begin
            seen_w = 1'b1;
            check("min_glen", 32'(bus.green_len), 32'd5);
         end
      end
      check("seen_south", 32'(seen_s), 32'd1);
`ifndef PRIORITY_SKIP_EN
      check("seen_west", 32'(seen_w), 32'd1);
`endif

      // Sparse timebase: tick on every 4th clock.
      set_avgs(20, 20, 20, 20);
      for (int i = 0; i < 300; i++) begin
         bus.tick = (i % 4 == 0);
         cycle();
      end

      // Reset in the middle of an East green with remaining = 6.
      bus.tick = 1'b1;
      found    = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         cycle();
         if (bus.green == 4'b0010 && bus.remaining == 8'd6) found = 1'b1;
      end
      check("mid_green_reached", 32'(found), 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("mid_rst_road",    32'(bus.next_road), 32'd3);
      check("mid_rst_all_red", 32'(bus.all_red),   32'd1);
      check("mid_rst_green",   32'(bus.green),     32'd0);
      cycle();
      cycle();
      check("mid_rst_north", 32'(bus.green), 32'b0001);

      // Randomized traffic, timebase and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.tick = ($urandom_range(0, 3) != 0);
         reset    = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) set_avgs(rand_avg(), rand_avg(), rand_avg(), rand_avg());
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Four-way intersection signal controller that consumes the moving-average vehicle counts produced by the per-direction sensor units and drives their shared `next_road` select. Each cycle it selects the next road, sizes that road's green time from the road's average count, and sequences the signal lamps through green, yellow and all-red. It is the consumer and driver end of the sensor interface: the sensors publish `avg`, and this block decides when each road is served by updating `next_road`.

## Interface
- `MIN_GREEN`, 5: minimum green duration, in ticks
- `MAX_GREEN`, 30: green duration saturation limit, in ticks
- `YELLOW_T`, 3: yellow duration, in ticks (≥1)
- `ALL_RED_T`, 1: all-red clearance duration, in ticks (≥1)
- `SCALE_SHIFT`, 2: right-shift applied to `avg` before adding it to `MIN_GREEN`
- `SKIP_THRESH`, 4: skip threshold, used only when `PRIORITY_SKIP_EN` is defined
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  reset, synchronous, active-high
- `tick`  in  1  one-clock timebase strobe; timers advance only on clocks where `tick`=1
- `avg_north`, `avg_east`, `avg_south`, `avg_west`  in  8 each  sensor averages
- `next_road`  out  2  road currently served: 0=N, 1=E, 2=S, 3=W; wired to all sensors
- `green`  out  4  one-hot green lamps, bit index = road code
- `yellow`  out  4  one-hot yellow lamps, bit index = road code
- `all_red`  out  1  high during the ALL_RED state
- `green_len`  out  8  green duration latched for the current phase
- `remaining`  out  8  ticks left in the current phase
- `phase_start`  out  1  one-clock pulse on entry to GREEN

## Operation
- States are RED_CLR, SELECT, GREEN and YELLOW.
- RED_CLR: `all_red`=1. Load `remaining`=`ALL_RED_T` on entry. When `remaining` expires, go to SELECT.
- SELECT lasts exactly one clock and does not wait for `tick`.
  - Candidate is (`next_road`+1) mod 4.
  - Sample the candidate's avg as `a`.
  - `green_len` = min(`MIN_GREEN` + (`a` >> `SCALE_SHIFT`), `MAX_GREEN`). Compute the sum in 9 bits, then saturate.
  - Update `next_road` to the candidate.
  - Load `remaining`=`green_len`.
  - Go to GREEN.
- GREEN: `green[next_road]`=1. When `remaining` expires, load `remaining`=`YELLOW_T` and go to YELLOW.
- YELLOW: `yellow[next_road]`=1. When `remaining` expires, load `remaining`=`ALL_RED_T` and go to RED_CLR.
- Expiry rule for a phase of length N:
  - `remaining` decrements on each clock with `tick`=1.
  - The transition fires on the clock where `tick`=1 and `remaining`=1.
  - Result: the phase lasts exactly N ticks.
- Lamp exclusivity: at most one bit of `green|yellow` is set, and never in the same cycle as `all_red`.
- `next_road` changes only in SELECT. It is held stable through GREEN, YELLOW and RED_CLR.
- `avg` inputs are ignored outside SELECT.
- Reset, in any state including mid-phase:
  - state = RED_CLR
  - `next_road`=3, so the first road served is N
  - `green`=0, `yellow`=0, `all_red`=1
  - `green_len`=0, `remaining`=`ALL_RED_T`, `phase_start`=0
- Reset dominates `tick` on the same clock.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- SELECT→GREEN costs exactly one clock after the final RED_CLR tick.
- `phase_start` is high on the first GREEN clock.
- `green_len` and `next_road` are valid from the first GREEN clock.
- `tick` held constantly high: each phase lasts N clocks, plus one SELECT clock per rotation.
- Simultaneous `tick` with the SELECT clock: the tick is not counted against the new green phase.

## Configuration
- `PRIORITY_SKIP_EN` undefined: strict round-robin N→E→S→W.
- `PRIORITY_SKIP_EN` defined: SELECT picks the first road in round-robin order after `next_road`, searching up to 4 roads including the current one, whose avg ≥ `SKIP_THRESH`.
  - If no road qualifies, use (`next_road`+1) mod 4.
  - The selection is still a single SELECT clock.

## Test plan
- All avgs=20, `tick` every clock after reset → first green on N with `green_len`=10. Then the sequence is G10, Y3, R1, SELECT, then E with the same timing. `next_road` steps 0,1,2,3,0.
- `avg_south`=255 → `green_len`=30 (saturated). `avg_west`=0 → `green_len`=5.
- `tick` pulses every 4th clock, YELLOW_T=3 → yellow stays asserted for exactly 3 ticks (12 clocks ±phase alignment). `remaining` counts 3,2,1.
- Reset asserted mid-GREEN on E with `remaining`=6 → the next clock shows reset values, `all_red`=1, `next_road`=3. After one tick, N is served.
- With `PRIORITY_SKIP_EN`: `avg_east`=2, others 20 → served order N,S,W,N.
- With `PRIORITY_SKIP_EN`: all avgs=2 → order N,E,S,W. Every cycle, check that `green`/`yellow`/`all_red` are mutually exclusive and each is one-hot.
